mem_stage_lsu: RTL

Parametrised successor to the MEM pipeline stage. It sits between the EX/MEM and MEM/WB pipeline registers and holds a byte-addressed, little-endian data memory. It adds configurable access latency with a stall handshake, true byte-lane addressing, signed/unsigned loads and misalignment detection. It drives the MEM/WB register for writeback.

---
 rtl/mem_stage_lsu_if.sv | 30 +++
 rtl/mem_stage_lsu.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: EX/MEM inputs, MEM/WB outputs and the stall handshake of the LSU stage
interface mem_stage_lsu_if;
   logic [31:0] EXMEM_alu;
   logic [31:0] EXMEM_b;
   logic [4:0]  EXMEM_reg_write_address;
   logic [1:0]  EXMEM_ctrl_mem_read;
   logic [1:0]  EXMEM_ctrl_mem_write;
   logic        EXMEM_ctrl_unsigned;
   logic        EXMEM_ctrl_reg_write;
   logic        EXMEM_ctrl_mem_to_reg;
   logic        stall;
   logic [31:0] MEMWB_mem;
   logic [31:0] MEMWB_alu;
   logic [4:0]  MEMWB_reg_write_address;
   logic        MEMWB_ctrl_reg_write;
   logic        MEMWB_ctrl_mem_to_reg;
   logic        MEMWB_misalign;
   modport master (
      output EXMEM_alu, EXMEM_b, EXMEM_reg_write_address, EXMEM_ctrl_mem_read,
             EXMEM_ctrl_mem_write, EXMEM_ctrl_unsigned, EXMEM_ctrl_reg_write, EXMEM_ctrl_mem_to_reg,
      input  stall, MEMWB_mem, MEMWB_alu, MEMWB_reg_write_address, MEMWB_ctrl_reg_write,
             MEMWB_ctrl_mem_to_reg, MEMWB_misalign
   );
   modport slave (
      input  EXMEM_alu, EXMEM_b, EXMEM_reg_write_address, EXMEM_ctrl_mem_read,
             EXMEM_ctrl_mem_write, EXMEM_ctrl_unsigned, EXMEM_ctrl_reg_write, EXMEM_ctrl_mem_to_reg,
      output stall, MEMWB_mem, MEMWB_alu, MEMWB_reg_write_address, MEMWB_ctrl_reg_write,
             MEMWB_ctrl_mem_to_reg, MEMWB_misalign
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage with byte-lane data memory, multi-cycle access stall and misalignment suppression
`ifndef WORD
`define WORD 2'b11
`endif
`ifndef HALFWORD
`define HALFWORD 2'b10
`endif
`ifndef BYTE
`define BYTE 2'b01
`endif
module mem_stage_lsu #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   mem_stage_lsu_if.slave bus
);
   localparam int WI = ADDR_W - 2;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] mem_q [2**WI];
   logic [31:0] memwb_mem_q, memwb_mem_d, memwb_alu_q, memwb_alu_d;
   logic [4:0]  memwb_ra_q, memwb_ra_d;
   logic        memwb_rw_q, memwb_rw_d, memwb_m2r_q, memwb_m2r_d, memwb_mis_q, memwb_mis_d;
   logic        rd_v, wr_v, mem_op, mis, load, done, stall_raw, we;
   logic [1:0]  size;
   logic [ADDR_W-1:0] addr;
   logic [WI-1:0] widx;
   logic [31:0] word, sh, ldata, wdata;
   logic [3:0]  be;
   // decode the op, extract load lanes and build store lane enables
   always_comb begin
      rd_v   = |bus.EXMEM_ctrl_mem_read;
      wr_v   = |bus.EXMEM_ctrl_mem_write;
      mem_op = rd_v | wr_v;
      load   = rd_v & !wr_v;
      size   = wr_v ? bus.EXMEM_ctrl_mem_write : bus.EXMEM_ctrl_mem_read;
      addr   = bus.EXMEM_alu[ADDR_W-1:0];
      widx   = addr[ADDR_W-1:2];
      mis    = mem_op & ((size == `HALFWORD && addr[0]) || (size == `WORD && addr[1:0] != 2'b00));
      word   = mem_q[widx];
      sh     = word >> {addr[1:0], 3'b000};
      ldata  = size == `BYTE ? {{24{sh[7] & !bus.EXMEM_ctrl_unsigned}}, sh[7:0]} :
               size == `HALFWORD ? {{16{sh[15] & !bus.EXMEM_ctrl_unsigned}}, sh[15:0]} : word;
      be     = size == `BYTE ? 4'b0001 << addr[1:0] : size == `HALFWORD ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata  = size == `BYTE ? {4{bus.EXMEM_b[7:0]}} : size == `HALFWORD ? {2{bus.EXMEM_b[15:0]}} : bus.EXMEM_b;
      stall_raw = state_q == BUSY ? cnt_q != 4'd0 : (mem_op && !mis && LATENCY > 1);
      done   = state_q == BUSY ? cnt_q == 4'd0 : (mem_op && !mis && LATENCY == 1);
      we     = done & wr_v & !rst_i;
   end
   // access FSM and MEM/WB next values; stall cycles retire bubbles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE && stall_raw) begin
         state_d = BUSY;
         cnt_d   = 4'(LATENCY - 2);
      end else if (state_q == BUSY) begin
         state_d = cnt_q == 4'd0 ? IDLE : BUSY;
         cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      memwb_alu_d = stall_raw ? 32'd0 : bus.EXMEM_alu;
      memwb_ra_d  = stall_raw ? 5'd0 : bus.EXMEM_reg_write_address;
      memwb_rw_d  = !stall_raw & !mis & bus.EXMEM_ctrl_reg_write;
      memwb_m2r_d = !stall_raw & bus.EXMEM_ctrl_mem_to_reg;
      memwb_mis_d = !stall_raw & mis;
      memwb_mem_d = (done && load) ? ldata : 32'd0;
   end
   // state and MEM/WB pipeline register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         memwb_mem_q <= 32'd0;
         memwb_alu_q <= 32'd0;
         memwb_ra_q  <= 5'd0;
         memwb_rw_q  <= 1'b0;
         memwb_m2r_q <= 1'b0;
         memwb_mis_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         memwb_mem_q <= memwb_mem_d;
         memwb_alu_q <= memwb_alu_d;
         memwb_ra_q  <= memwb_ra_d;
         memwb_rw_q  <= memwb_rw_d;
         memwb_m2r_q <= memwb_m2r_d;
         memwb_mis_q <= memwb_mis_d;
      end
   end
   // data memory keeps its contents across reset; only enabled lanes are written on completion
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
   end
   assign bus.stall                   = stall_raw & !rst_i;
   assign bus.MEMWB_mem               = memwb_mem_q;
   assign bus.MEMWB_alu               = memwb_alu_q;
   assign bus.MEMWB_reg_write_address = memwb_ra_q;
   assign bus.MEMWB_ctrl_reg_write    = memwb_rw_q;
   assign bus.MEMWB_ctrl_mem_to_reg   = memwb_m2r_q;
   assign bus.MEMWB_misalign          = memwb_mis_q;
endmodule
